// File: rtl/hazard_detection_unit.sv
// Stall/flush controller for the 5-stage pipeline: load-use bubbles, data-memory
// hold with timeout, taken-branch flushes, plus saturating stall/flush statistics.
module hazard_detection_unit #(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned MEM_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       IF_ID_RegisterRn1,
    input  logic [4:0]       IF_ID_RegisterRm2,
    input  logic             IF_ID_UsesRn,
    input  logic             IF_ID_UsesRm,
    input  logic             ID_EX_MemRead,
    input  logic [4:0]       ID_EX_RegisterRd,
    input  logic             EX_MEM_MemAccess,
    input  logic             EX_MEM_BranchTaken,
    input  logic             dmem_ready,
    output logic             PC_Write,
    output logic             PCSrc,
    output logic             IF_ID_Write,
    output logic             ID_EX_Bubble,
    output logic             Pipe_Hold,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Flush,
    output logic             EX_MEM_Flush,
    output logic             mem_error,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic {RUN, MEM_WAIT} state_t;

    localparam logic [CNT_W-1:0] TIMEOUT = CNT_W'(MEM_TIMEOUT);

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_wait_cnt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic             r_mem_error;

    logic             w_hold;
    logic             w_branch;
    logic             w_load_use;
    logic             w_rn_hit;
    logic             w_rm_hit;
    logic [CNT_W-1:0] w_wait_inc;

    assign w_hold = (r_state == RUN && EX_MEM_MemAccess && !dmem_ready) ||
                    (r_state == MEM_WAIT && !dmem_ready);
    assign w_branch = !w_hold && EX_MEM_BranchTaken;

    // XZR (register 31) as load destination never produces a hazard
    assign w_rn_hit   = IF_ID_UsesRn && (IF_ID_RegisterRn1 == ID_EX_RegisterRd);
    assign w_rm_hit   = IF_ID_UsesRm && (IF_ID_RegisterRm2 == ID_EX_RegisterRd);
    assign w_load_use = !w_hold && !w_branch && ID_EX_MemRead &&
                        (ID_EX_RegisterRd != 5'd31) && (w_rn_hit || w_rm_hit);

    assign w_wait_inc = (r_wait_cnt == '1) ? r_wait_cnt : r_wait_cnt + CNT_W'(1);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            RUN:      if (w_hold) w_next_state = MEM_WAIT;
            MEM_WAIT: if (dmem_ready) w_next_state = RUN;
            default:  w_next_state = RUN;
        endcase
    end

    always_comb begin
        PC_Write     = 1'b1;
        IF_ID_Write  = 1'b1;
        PCSrc        = 1'b0;
        ID_EX_Bubble = 1'b0;
        Pipe_Hold    = 1'b0;
        IF_ID_Flush  = 1'b0;
        ID_EX_Flush  = 1'b0;
        EX_MEM_Flush = 1'b0;
        if (reset) begin
            PC_Write     = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Bubble = 1'b1;
            Pipe_Hold    = 1'b1;
        end else if (w_hold) begin
            PC_Write    = 1'b0;
            IF_ID_Write = 1'b0;
            Pipe_Hold   = 1'b1;
        end else if (w_branch) begin
            PCSrc        = 1'b1;
            IF_ID_Flush  = 1'b1;
            ID_EX_Flush  = 1'b1;
            EX_MEM_Flush = 1'b1;
        end else if (w_load_use) begin
            PC_Write     = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Bubble = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= RUN;
            r_wait_cnt  <= '0;
            r_mem_error <= 1'b0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_hold) begin
                r_wait_cnt <= w_wait_inc;
                if (w_wait_inc >= TIMEOUT) r_mem_error <= 1'b1;
            end else begin
                r_wait_cnt <= '0;
            end
            // PC_Write=0 covers both hold and load-use exactly once per cycle
            if (!PC_Write && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if (w_branch && r_flush_cnt != '1) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
        end
    end

    assign mem_error   = r_mem_error;
    assign stall_count = r_stall_cnt;
    assign flush_count = r_flush_cnt;

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Scoreboard bench for hazard_detection_unit: stimulus pushes hand-computed
// expectations, a negedge monitor pops and compares them.
module tb_hazard_detection_unit;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] rn = '0, rm = '0, rd = '0;
    logic       urn = 1'b0, urm = 1'b0, mr = 1'b0, ma = 1'b0, br = 1'b0, rdy = 1'b1;

    logic       pc_write, pcsrc, ifid_write, bubble, hold, f_ifid, f_idex, f_exmem, mem_err;
    logic [2:0] stall_cnt, flush_cnt;

    hazard_detection_unit #(.CNT_W(3), .MEM_TIMEOUT(4)) dut (
        .clk(clk), .reset(reset),
        .IF_ID_RegisterRn1(rn), .IF_ID_RegisterRm2(rm),
        .IF_ID_UsesRn(urn), .IF_ID_UsesRm(urm),
        .ID_EX_MemRead(mr), .ID_EX_RegisterRd(rd),
        .EX_MEM_MemAccess(ma), .EX_MEM_BranchTaken(br), .dmem_ready(rdy),
        .PC_Write(pc_write), .PCSrc(pcsrc), .IF_ID_Write(ifid_write),
        .ID_EX_Bubble(bubble), .Pipe_Hold(hold),
        .IF_ID_Flush(f_ifid), .ID_EX_Flush(f_idex), .EX_MEM_Flush(f_exmem),
        .mem_error(mem_err), .stall_count(stall_cnt), .flush_count(flush_cnt)
    );

    always #5 clk = ~clk;

    // {PC_Write, PCSrc, IF_ID_Write, Bubble, Pipe_Hold, IF_ID_Fl, ID_EX_Fl, EX_MEM_Fl, mem_error}
    localparam logic [8:0] C_RST  = 9'b0_0_0_1_1_000_0;
    localparam logic [8:0] C_DEF  = 9'b1_0_1_0_0_000_0;
    localparam logic [8:0] C_LU   = 9'b0_0_0_1_0_000_0;
    localparam logic [8:0] C_HOLD = 9'b0_0_0_0_1_000_0;
    localparam logic [8:0] C_BR   = 9'b1_1_1_0_0_111_0;
    localparam logic [8:0] C_ERR  = 9'b0_0_0_0_0_000_1;

    typedef struct packed {
        logic [15:0] id;
        logic [8:0]  ctl;
        logic [2:0]  sc;
        logic [2:0]  fc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   passed = 0;
    int   vec_id = 0;

    task automatic step(input logic i_rst, input logic [4:0] i_rn, input logic i_urn,
                        input logic [4:0] i_rm, input logic i_urm, input logic i_mr,
                        input logic [4:0] i_rd, input logic i_ma, input logic i_br,
                        input logic i_rdy, input logic [8:0] e_ctl,
                        input logic [2:0] e_sc, input logic [2:0] e_fc);
        exp_t e;
        @(posedge clk);
        #1;
        reset = i_rst; rn = i_rn; urn = i_urn; rm = i_rm; urm = i_urm;
        mr = i_mr; rd = i_rd; ma = i_ma; br = i_br; rdy = i_rdy;
        e.id = 16'(vec_id); e.ctl = e_ctl; e.sc = e_sc; e.fc = e_fc;
        vec_id++;
        q.push_back(e);
    endtask

    task automatic idle(input logic [8:0] e_ctl, input logic [2:0] e_sc, input logic [2:0] e_fc);
        step(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, e_ctl, e_sc, e_fc);
    endtask

    task automatic do_reset;
        step(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, C_RST, 3'd0, 3'd0);
    endtask

    task automatic mem(input logic i_rdy, input logic [8:0] e_ctl,
                       input logic [2:0] e_sc, input logic [2:0] e_fc);
        step(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, i_rdy, e_ctl, e_sc, e_fc);
    endtask

    always @(negedge clk) begin
        exp_t       e;
        logic [8:0] act;
        if (q.size() != 0) begin
            e   = q.pop_front();
            act = {pc_write, pcsrc, ifid_write, bubble, hold, f_ifid, f_idex, f_exmem, mem_err};
            checks++;
            if (act === e.ctl && stall_cnt === e.sc && flush_cnt === e.fc)
                passed++;
            else
                $display("FAIL vec%0d: ctl=%b stall=%0d flush=%0d, expected ctl=%b stall=%0d flush=%0d",
                         e.id, act, stall_cnt, flush_cnt, e.ctl, e.sc, e.fc);
        end
    end

    initial begin
        // reset state and defaults
        do_reset;
        idle(C_DEF, 3'd0, 3'd0);
        // load-use on Rn, one-cycle stall
        step(1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1, C_LU, 3'd0, 3'd0);
        idle(C_DEF, 3'd1, 3'd0);
        // XZR destination and unused Rn: no stall
        step(1'b0, 5'd31, 1'b1, 5'd0, 1'b0, 1'b1, 5'd31, 1'b0, 1'b0, 1'b1, C_DEF, 3'd1, 3'd0);
        step(1'b0, 5'd5, 1'b0, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1, C_DEF, 3'd1, 3'd0);
        // load-use on Rm
        step(1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b1, C_LU, 3'd1, 3'd0);
        idle(C_DEF, 3'd2, 3'd0);

        // memory wait: 3 hold cycles then release
        do_reset;
        mem(1'b0, C_HOLD, 3'd0, 3'd0);
        mem(1'b0, C_HOLD, 3'd1, 3'd0);
        mem(1'b0, C_HOLD, 3'd2, 3'd0);
        mem(1'b1, C_DEF, 3'd3, 3'd0);
        // back in RUN: dmem_ready low with no access must not hold
        step(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, C_DEF, 3'd3, 3'd0);
        mem(1'b1, C_DEF, 3'd3, 3'd0);

        // branch flush
        step(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, C_BR, 3'd3, 3'd0);
        idle(C_DEF, 3'd3, 3'd1);
        // branch beats load-use
        step(1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b1, 1'b1, C_BR, 3'd3, 3'd1);
        idle(C_DEF, 3'd3, 3'd2);
        // memory hold beats load-use
        step(1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, C_HOLD, 3'd3, 3'd2);
        mem(1'b1, C_DEF, 3'd4, 3'd2);
        // branch applies in the cycle MEM_WAIT completes
        mem(1'b0, C_HOLD, 3'd4, 3'd2);
        step(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1, C_BR, 3'd5, 3'd2);
        idle(C_DEF, 3'd5, 3'd3);

        // timeout after 4 hold cycles, sticky, cleared only by reset
        do_reset;
        for (int i = 0; i < 10; i++)
            mem(1'b0, C_HOLD | (i >= 4 ? C_ERR : 9'd0), (i > 7) ? 3'd7 : 3'(i), 3'd0);
        mem(1'b1, C_DEF | C_ERR, 3'd7, 3'd0);
        idle(C_DEF | C_ERR, 3'd7, 3'd0);
        mem(1'b0, C_HOLD | C_ERR, 3'd7, 3'd0);
        step(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, C_RST, 3'd0, 3'd0);
        step(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, C_DEF, 3'd0, 3'd0);

        // stall_count saturation
        do_reset;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 5'd3, 1'b1, 5'd0, 1'b0, 1'b1, 5'd3, 1'b0, 1'b0, 1'b1, C_LU,
                 (i > 7) ? 3'd7 : 3'(i), 3'd0);
            idle(C_DEF, (i >= 6) ? 3'd7 : 3'(i + 1), 3'd0);
        end
        // flush_count saturation
        for (int i = 0; i < 9; i++)
            step(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, C_BR,
                 3'd7, (i > 7) ? 3'd7 : 3'(i));
        idle(C_DEF, 3'd7, 3'd7);

        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            checks++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

endmodule
